// File: rtl/single_clock_fifo_flagged.sv
// rtl/single_clock_fifo_flagged.sv - single-clock FIFO with occupancy flags, sticky errors, selectable read mode
// Capacity is tracked by an explicit word counter, so the full depth is usable.
module single_clock_fifo_flagged #(
   parameter int DATAWIDTH          = 8,
   parameter int DATADEPTH          = 16,
   parameter int ALMOST_FULL_LEVEL  = DATADEPTH - 2,
   parameter int ALMOST_EMPTY_LEVEL = 2,
   parameter int FWFT               = 0,
   localparam int ADDRESSWIDTH      = $clog2(DATADEPTH),
   localparam int COUNTWIDTH        = ADDRESSWIDTH + 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  write_en,
   input  logic [DATAWIDTH-1:0]  data_in,
   input  logic                  read_req,
   output logic [DATAWIDTH-1:0]  data_out,
   output logic                  data_valid,
   output logic [COUNTWIDTH-1:0] word_count,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [COUNTWIDTH-1:0] FULL_COUNT   = COUNTWIDTH'(DATADEPTH);
   localparam logic [COUNTWIDTH-1:0] AFULL_COUNT  = COUNTWIDTH'(ALMOST_FULL_LEVEL);
   localparam logic [COUNTWIDTH-1:0] AEMPTY_COUNT = COUNTWIDTH'(ALMOST_EMPTY_LEVEL);

   logic [DATAWIDTH-1:0]    storage [DATADEPTH];
   logic [ADDRESSWIDTH-1:0] write_pointer;
   logic [ADDRESSWIDTH-1:0] read_pointer;
   logic [COUNTWIDTH-1:0]   count_q;
   logic                    overflow_q;
   logic                    underflow_q;
   logic                    write_accept;
   logic                    read_accept;
   logic [DATAWIDTH-1:0]    head_word;

   // Flags come from the registered count, so they lag the request by one edge.
   assign empty        = (count_q == '0);
   assign full         = (count_q == FULL_COUNT);
   assign almost_full  = (count_q >= AFULL_COUNT);
   assign almost_empty = (count_q <= AEMPTY_COUNT);
   assign word_count   = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign write_accept = write_en && !full && !clear;
   assign read_accept  = read_req && !empty && !clear;
   assign head_word    = storage[read_pointer];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_pointer <= '0;
         read_pointer  <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else if (clear) begin
         write_pointer <= '0;
         read_pointer  <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         if (write_accept) write_pointer <= write_pointer + 1'b1;
         if (read_accept)  read_pointer  <= read_pointer + 1'b1;
         case ({write_accept, read_accept})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (write_en && full)  overflow_q  <= 1'b1;
         if (read_req && empty) underflow_q <= 1'b1;
      end
   end

   // Storage is never reset; the pointers alone define which words are live.
   always_ff @(posedge clk) begin
      if (write_accept) storage[write_pointer] <= data_in;
   end

   generate
      if (FWFT == 0) begin : g_registered
         logic [DATAWIDTH-1:0] data_q;
         logic                 valid_q;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else if (clear) begin
               data_q  <= '0;
               valid_q <= 1'b0;
            end else if (read_accept) begin
               data_q  <= head_word;
               valid_q <= 1'b1;
            end else begin
               valid_q <= 1'b0;
            end
         end

         assign data_out   = data_q;
         assign data_valid = valid_q;
      end else begin : g_fwft
         assign data_out   = head_word;
         assign data_valid = !empty;
      end
   endgenerate

endmodule

// File: doc/single_clock_fifo_flagged.md
SINGLE_CLOCK_FIFO_FLAGGED -- requirements
Module: single_clock_fifo_flagged

Interface
REQ-001 Parameter DATAWIDTH, default 8, width in bits of one stored word.
REQ-002 Parameter DATADEPTH, default 16, capacity in words; SHALL be a power of two and at least 4.
REQ-003 Parameter ALMOST_FULL_LEVEL, default DATADEPTH-2, the word count at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_LEVEL, default 2, the word count at or below which almost_empty asserts.
REQ-005 Parameter FWFT, default 0, selects read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 Derived ADDRESSWIDTH = $clog2(DATADEPTH); COUNTWIDTH = ADDRESSWIDTH+1.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 clear  in  1  synchronous flush of all FIFO state.
REQ-010 write_en  in  1  write request.
REQ-011 data_in  in  DATAWIDTH  write data.
REQ-012 read_req  in  1  read request (pop).
REQ-013 data_out  out  DATAWIDTH  read data.
REQ-014 data_valid  out  1  data_out holds a valid popped or head word.
REQ-015 word_count  out  COUNTWIDTH  number of stored words, 0..DATADEPTH.
REQ-016 empty, full, almost_empty, almost_full  out  1 each  occupancy flags.
REQ-017 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-018 Write accepted = write_en && !full && !clear; the word is stored at write_pointer, which then increments.
REQ-019 Read accepted = read_req && !empty && !clear; read_pointer then increments.
REQ-020 Pointers are ADDRESSWIDTH bits and wrap from DATADEPTH-1 to 0 with no special handling.
REQ-021 word_count: +1 on write-only, -1 on read-only, unchanged on simultaneous accepted read and write, unchanged on rejected requests.
REQ-022 Full capacity is DATADEPTH words: full = (word_count == DATADEPTH); empty = (word_count == 0).
REQ-023 almost_full = (word_count >= ALMOST_FULL_LEVEL); almost_empty = (word_count <= ALMOST_EMPTY_LEVEL).
REQ-024 All flags derive from the registered word_count, so they update one edge after the causing request.
REQ-025 write_en while full: the write is dropped, storage is unchanged, and overflow sets at the next edge. A simultaneous read is still accepted.
REQ-026 read_req while empty: nothing is popped, pointers are unchanged, and underflow sets at the next edge. A simultaneous write is still accepted.
REQ-027 overflow and underflow stay set until clear or reset.
REQ-028 FWFT=0: on an accepted read, data_out loads the word at read_pointer at that edge and data_valid is 1 for exactly the following cycle. Otherwise data_out holds its value and data_valid is 0. Latency is 1 cycle.
REQ-029 FWFT=1: data_out continuously shows the word at read_pointer and data_valid = !empty. A word written into an empty FIFO is visible one edge after its write, and read_req acknowledges (pops) the shown word.
REQ-030 clear has priority over write_en and read_req in the same cycle. At the next edge it zeroes the pointers, word_count, overflow and underflow. In FWFT=0 it also zeroes data_out and data_valid.
REQ-031 Storage contents are not reset or cleared. Only the pointers define validity.
REQ-032 Storage is an internal register array (DATADEPTH x DATAWIDTH) with one write port and one read port.

Reset
REQ-033 When reset_n is low: pointers = 0, word_count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, data_valid = 0, and data_out = 0 in FWFT=0.
REQ-034 Reset takes effect immediately, asynchronously, including mid-transfer. Operation resumes on the first rising edge after reset_n goes high.

Verification
REQ-035 Defaults, FWFT=0: write 0x01..0x10 over 16 cycles -> full=1, word_count=16, almost_full from count 14. Then 16 reads -> data_out 0x01..0x10, each with a 1-cycle data_valid pulse; empty=1 after the last read.
REQ-036 Full FIFO with write_en=1 and read_req=1 in the same cycle -> read accepted, write dropped, overflow=1, word_count=15. Then clear -> overflow=0, word_count=0, empty=1.
REQ-037 Empty FIFO with read_req=1 -> underflow=1, data_valid=0, pointers unchanged. Write 0xAA with read_req=1 in the same cycle -> word_count=1.
REQ-038 Wrap-around: 10 writes, 10 reads, 10 writes, 10 reads -> data in order, word_count never above 10, no error flags.
REQ-039 FWFT=1: write 0x5A into an empty FIFO -> next cycle data_out=0x5A and data_valid=1. read_req=1 for that cycle -> empty=1 and data_valid=0 after the edge.
REQ-040 Assert reset_n=0 asynchronously with 7 words stored and a read in flight -> all outputs take the REQ-033 values before the next clk edge. Then 3 writes of 0x33 read back as 0x33 x3.
